// File: rtl/cp_bypass_ctrl_pkg.sv
// Shared CP bypass constants: result-source codes and register index width,
// mirroring the shared CP definitions so every bypass block agrees on encoding.
package cp_bypass_ctrl_pkg;

   localparam int DEF_CP_RF_INDEX_WIDTH = 5;

   typedef logic [1:0] bp_src_t;

   localparam bp_src_t RISC24_CP_BYPASS_SRC_ALU    = 2'd0;
   localparam bp_src_t RISC24_CP_BYPASS_SRC_MUL    = 2'd1;
   localparam bp_src_t RISC24_CP_BYPASS_SRC_LSU    = 2'd2;
   localparam bp_src_t RISC24_CP_BYPASS_SRC_SHADOW = 2'd3;

endpackage

// File: rtl/cp_bypass_ctrl_cmp.sv
// Per-port comparator: matches one IF read port against the ID entry and
// forwards the producer's result source as the bypass select.
module cp_bypass_cmp
   import cp_bypass_ctrl_pkg::*;
#(
   parameter int RF_INDEX_WIDTH = DEF_CP_RF_INDEX_WIDTH
) (
   input  logic                      if_valid,
   input  logic                      read_en,
   input  logic [RF_INDEX_WIDTH-1:0] read_addr,
   input  logic                      id_valid,
   input  logic [RF_INDEX_WIDTH-1:0] id_dest,
   input  bp_src_t                   id_src,
   output logic                      match,
   output bp_src_t                   sel
);

   // id_valid already excludes r0, so no explicit zero check is needed here
   assign match = if_valid && read_en && id_valid && (read_addr == id_dest);
   assign sel   = match ? id_src : RISC24_CP_BYPASS_SRC_ALU;

endmodule

// File: rtl/cp_bypass_ctrl.sv
// IF-stage bypass/hazard control: tracks the ID-stage producer, registers
// per-port bypass flags/selects for cp_bypass, and requests load-use bubbles.
module cp_bypass_ctrl
   import cp_bypass_ctrl_pkg::*;
#(
   parameter int RF_INDEX_WIDTH = DEF_CP_RF_INDEX_WIDTH,
   parameter int LOAD_USE_STALL = 0
) (
   input  logic                      iClk,
   input  logic                      iReset_n,
   input  logic                      iIF_Valid,
   input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_A,
   input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_B,
   input  logic                      iIF_Read_En_A,
   input  logic                      iIF_Read_En_B,
   input  logic [RF_INDEX_WIDTH-1:0] iIF_Write_Addr,
   input  logic                      iIF_Write_En,
   input  logic [1:0]                iIF_Result_Src,
   input  logic                      iStall,
   input  logic                      iFlush,
   output logic                      oIF_BP_Bypass_Read_A,
   output logic                      oIF_BP_Bypass_Read_B,
   output logic [1:0]                oIF_BP_Bypass_Sel_A,
   output logic [1:0]                oIF_BP_Bypass_Sel_B,
   output logic                      oHazard_Stall
);

   logic                      id_valid;
   logic [RF_INDEX_WIDTH-1:0] id_dest;
   bp_src_t                   id_src;

   logic    match_a;
   logic    match_b;
   bp_src_t sel_a;
   bp_src_t sel_b;
   logic    issue_valid;

   cp_bypass_cmp #(.RF_INDEX_WIDTH(RF_INDEX_WIDTH)) u_cmp_a (
      .if_valid  (iIF_Valid),
      .read_en   (iIF_Read_En_A),
      .read_addr (iIF_RF_Read_Addr_A),
      .id_valid  (id_valid),
      .id_dest   (id_dest),
      .id_src    (id_src),
      .match     (match_a),
      .sel       (sel_a)
   );

   cp_bypass_cmp #(.RF_INDEX_WIDTH(RF_INDEX_WIDTH)) u_cmp_b (
      .if_valid  (iIF_Valid),
      .read_en   (iIF_Read_En_B),
      .read_addr (iIF_RF_Read_Addr_B),
      .id_valid  (id_valid),
      .id_dest   (id_dest),
      .id_src    (id_src),
      .match     (match_b),
      .sel       (sel_b)
   );

   assign oHazard_Stall = (LOAD_USE_STALL != 0) && (match_a || match_b) &&
                          (id_src == RISC24_CP_BYPASS_SRC_LSU) && !iFlush;

   assign issue_valid = iIF_Valid && iIF_Write_En && (iIF_Write_Addr != '0);

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         id_valid             <= 1'b0;
         id_dest              <= '0;
         id_src               <= RISC24_CP_BYPASS_SRC_ALU;
         oIF_BP_Bypass_Read_A <= 1'b0;
         oIF_BP_Bypass_Read_B <= 1'b0;
         oIF_BP_Bypass_Sel_A  <= RISC24_CP_BYPASS_SRC_ALU;
         oIF_BP_Bypass_Sel_B  <= RISC24_CP_BYPASS_SRC_ALU;
      end else if (iFlush) begin
         id_valid             <= 1'b0;
         oIF_BP_Bypass_Read_A <= 1'b0;
         oIF_BP_Bypass_Read_B <= 1'b0;
         oIF_BP_Bypass_Sel_A  <= RISC24_CP_BYPASS_SRC_ALU;
         oIF_BP_Bypass_Sel_B  <= RISC24_CP_BYPASS_SRC_ALU;
      end else if (iStall) begin
         id_valid <= id_valid;
      end else if (oHazard_Stall) begin
         // bubble: the held IF instruction later sees the load at distance 2,
         // which the RF write-port bypass covers without a flag
         id_valid             <= 1'b0;
         oIF_BP_Bypass_Read_A <= 1'b0;
         oIF_BP_Bypass_Read_B <= 1'b0;
         oIF_BP_Bypass_Sel_A  <= RISC24_CP_BYPASS_SRC_ALU;
         oIF_BP_Bypass_Sel_B  <= RISC24_CP_BYPASS_SRC_ALU;
      end else begin
         id_valid             <= issue_valid;
         id_dest              <= iIF_Write_Addr;
         id_src               <= iIF_Result_Src;
         oIF_BP_Bypass_Read_A <= match_a;
         oIF_BP_Bypass_Read_B <= match_b;
         oIF_BP_Bypass_Sel_A  <= sel_a;
         oIF_BP_Bypass_Sel_B  <= sel_b;
      end
   end

endmodule

// File: tb/tb_cp_bypass_ctrl.sv
// Bench for cp_bypass_ctrl: drives both LOAD_USE_STALL variants with the same
// stimulus and checks them against a per-variant pipeline model.
module tb_cp_bypass_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       if_valid;
   logic [4:0] ra, rb, wa;
   logic       ena, enb, we;
   logic [1:0] src;
   logic       stall, flush;

   logic [1:0] bra, brb, haz;
   logic [1:0] sela [2];
   logic [1:0] selb [2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cp_bypass_ctrl #(.RF_INDEX_WIDTH(5), .LOAD_USE_STALL(0)) dut0 (
      .iClk(clk), .iReset_n(rst_n), .iIF_Valid(if_valid),
      .iIF_RF_Read_Addr_A(ra), .iIF_RF_Read_Addr_B(rb),
      .iIF_Read_En_A(ena), .iIF_Read_En_B(enb),
      .iIF_Write_Addr(wa), .iIF_Write_En(we), .iIF_Result_Src(src),
      .iStall(stall), .iFlush(flush),
      .oIF_BP_Bypass_Read_A(bra[0]), .oIF_BP_Bypass_Read_B(brb[0]),
      .oIF_BP_Bypass_Sel_A(sela[0]), .oIF_BP_Bypass_Sel_B(selb[0]),
      .oHazard_Stall(haz[0])
   );

   cp_bypass_ctrl #(.RF_INDEX_WIDTH(5), .LOAD_USE_STALL(1)) dut1 (
      .iClk(clk), .iReset_n(rst_n), .iIF_Valid(if_valid),
      .iIF_RF_Read_Addr_A(ra), .iIF_RF_Read_Addr_B(rb),
      .iIF_Read_En_A(ena), .iIF_Read_En_B(enb),
      .iIF_Write_Addr(wa), .iIF_Write_En(we), .iIF_Result_Src(src),
      .iStall(stall), .iFlush(flush),
      .oIF_BP_Bypass_Read_A(bra[1]), .oIF_BP_Bypass_Read_B(brb[1]),
      .oIF_BP_Bypass_Sel_A(sela[1]), .oIF_BP_Bypass_Sel_B(selb[1]),
      .oHazard_Stall(haz[1])
   );

   // model: the ID-stage producer plus the registered outputs, per variant
   typedef struct {
      bit         v;
      logic [4:0] dest;
      logic [1:0] src;
      bit         fa, fb;
      logic [1:0] sa, sb;
   } mstate_t;
   mstate_t m [2];

   function automatic bit depends(int k, bit en, logic [4:0] addr);
      return if_valid && en && m[k].v && (addr == m[k].dest);
   endfunction

   function automatic bit exp_haz(int k);
      return (k == 1) && (depends(k, ena, ra) || depends(k, enb, rb)) &&
             (m[k].src == 2'd2) && !flush;
   endfunction

   function automatic void clear_model(int k, bit full);
      m[k].v  = 0;
      m[k].fa = 0; m[k].fb = 0;
      m[k].sa = 0; m[k].sb = 0;
      if (full) begin m[k].dest = 0; m[k].src = 0; end
   endfunction

   function automatic void advance(int k);
      bit da, db;
      if (flush) clear_model(k, 0);
      else if (stall) return;
      else if (exp_haz(k)) clear_model(k, 0);
      else begin
         da = depends(k, ena, ra);
         db = depends(k, enb, rb);
         m[k].fa = da;
         m[k].fb = db;
         m[k].sa = da ? m[k].src : 2'd0;
         m[k].sb = db ? m[k].src : 2'd0;
         m[k].v    = if_valid && we && (wa != 0);
         m[k].dest = wa;
         m[k].src  = src;
      end
   endfunction

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("flag_a[%0d]", k), {3'b0, bra[k]}, {3'b0, m[k].fa});
         chk($sformatf("flag_b[%0d]", k), {3'b0, brb[k]}, {3'b0, m[k].fb});
         chk($sformatf("sel_a[%0d]", k), {2'b0, sela[k]}, {2'b0, m[k].sa});
         chk($sformatf("sel_b[%0d]", k), {2'b0, selb[k]}, {2'b0, m[k].sb});
      end
   endtask

   // inputs must already be applied, away from the rising edge
   task automatic cycle();
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("hazard[%0d]", k), {3'b0, haz[k]}, {3'b0, exp_haz(k)});
      @(posedge clk);
      advance(0);
      advance(1);
      #1;
      chk_regs();
   endtask

   task automatic instr(bit v, logic [4:0] a, bit ea, logic [4:0] b, bit eb,
                        logic [4:0] w, bit e, logic [1:0] s);
      if_valid = v; ra = a; ena = ea; rb = b; enb = eb;
      wa = w; we = e; src = s; stall = 0; flush = 0;
   endtask

   initial begin
      rst_n = 0;
      instr(0, 0, 0, 0, 0, 0, 0, 0);
      clear_model(0, 1);
      clear_model(1, 1);
      #12;
      for (int k = 0; k < 2; k++) begin
         chk("rst_flag_a", {3'b0, bra[k]}, 4'd0);
         chk("rst_flag_b", {3'b0, brb[k]}, 4'd0);
         chk("rst_sel_a", {2'b0, sela[k]}, 4'd0);
         chk("rst_hazard", {3'b0, haz[k]}, 4'd0);
      end
      rst_n = 1;

      // back-to-back ALU dependency on A
      instr(1, 1, 1, 2, 1, 3, 1, 2'd0); cycle();
      instr(1, 3, 1, 4, 1, 9, 1, 2'd1); cycle();
      chk("alu_dep_flag_a", {3'b0, bra[0]}, 4'd1);
      chk("alu_dep_sel_a", {2'b0, sela[0]}, 4'd0);
      chk("alu_dep_flag_b", {3'b0, brb[0]}, 4'd0);

      // r0 write never matches
      instr(1, 1, 1, 2, 1, 0, 1, 2'd1); cycle();
      instr(1, 0, 1, 0, 1, 6, 1, 2'd0); cycle();
      chk("r0_flag_a", {3'b0, bra[0]}, 4'd0);
      chk("r0_flag_b", {3'b0, brb[1]}, 4'd0);

      // load-use on B
      instr(1, 1, 1, 2, 1, 5, 1, 2'd2); cycle();
      instr(1, 8, 1, 5, 1, 0, 0, 2'd0);
      #1;
      chk("lu_haz_on", {3'b0, haz[1]}, 4'd1);
      chk("lu_haz_off_cfg0", {3'b0, haz[0]}, 4'd0);
      cycle();
      chk("lu_bubble_flag_b", {3'b0, brb[1]}, 4'd0);
      chk("nolu_flag_b", {3'b0, brb[0]}, 4'd1);
      chk("nolu_sel_b", {2'b0, selb[0]}, 4'd2);
      cycle();
      chk("lu_reissue_haz", {3'b0, haz[1]}, 4'd0);
      chk("lu_reissue_flag_b", {3'b0, brb[1]}, 4'd0);

      // hold for three cycles with a dependency pending
      instr(1, 1, 1, 2, 1, 4, 1, 2'd1); cycle();
      instr(1, 4, 1, 2, 0, 0, 0, 2'd0);
      stall = 1;
      repeat (3) cycle();
      chk("hold_flag_a", {3'b0, bra[0]}, 4'd0);
      stall = 0; cycle();
      chk("release_flag_a", {3'b0, bra[0]}, 4'd1);
      chk("release_sel_a", {2'b0, sela[1]}, 4'd1);

      // flush together with stall
      instr(1, 1, 1, 2, 1, 7, 1, 2'd0); cycle();
      instr(1, 7, 1, 7, 1, 0, 0, 2'd0);
      stall = 1; flush = 1; cycle();
      chk("flush_flag_a", {3'b0, bra[0]}, 4'd0);
      instr(1, 7, 1, 1, 0, 0, 0, 2'd0); cycle();
      chk("post_flush_flag_a", {3'b0, bra[0]}, 4'd0);

      // async reset between edges while a flag is set
      instr(1, 1, 1, 2, 1, 3, 1, 2'd3); cycle();
      instr(1, 3, 1, 3, 1, 0, 0, 2'd0); cycle();
      chk("pre_rst_flag_a", {3'b0, bra[0]}, 4'd1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_flag_a", {3'b0, bra[0]}, 4'd0);
      chk("async_rst_flag_b", {3'b0, brb[1]}, 4'd0);
      chk("async_rst_sel_a", {2'b0, sela[0]}, 4'd0);
      clear_model(0, 1);
      clear_model(1, 1);
      @(negedge clk);
      rst_n = 1;

      // randomized traffic over a small register window to provoke matches
      for (int i = 0; i < 400; i++) begin
         instr($urandom_range(0, 7) != 0,
               5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)));
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cp_bypass_ctrl.md
# cp_bypass_ctrl

Bypass-control and hazard unit for the CP pipeline, sitting in the IF stage directly upstream of `cp_bypass`. It tracks the destination register and result source of the instruction currently in ID. It compares these against the read addresses of the instruction being fetched, and registers per-port bypass flags and source selects that `cp_bypass` consumes in ID. It also raises a one-bubble load-use stall when configured, and handles pipeline hold and flush.

## Interface
Parameters:
- `RF_INDEX_WIDTH`, `DEF_CP_RF_INDEX_WIDTH` (5): register index width.
- `LOAD_USE_STALL`, 0: 1 means an LSU result is not bypassable from EX, so a dependent instruction stalls one cycle.

Ports:
- `iClk` input 1: clock, rising edge.
- `iReset_n` input 1: reset, asynchronous and active-low.
- `iIF_Valid` input 1: IF holds a valid decoded instruction.
- `iIF_RF_Read_Addr_A` / `iIF_RF_Read_Addr_B` input RF_INDEX_WIDTH: source register indices.
- `iIF_Read_En_A` / `iIF_Read_En_B` input 1: the port is actually used (B is 0 when the immediate is selected).
- `iIF_Write_Addr` input RF_INDEX_WIDTH: destination index.
- `iIF_Write_En` input 1: the instruction writes the RF.
- `iIF_Result_Src` input 2: result source, encoded with the `RISC24_CP_BYPASS_SRC_*` codes (ALU/MUL/LSU/SHADOW).
- `iStall` input 1: external pipeline hold.
- `iFlush` input 1: branch/exception flush of IF/ID.
- `oIF_BP_Bypass_Read_A` / `oIF_BP_Bypass_Read_B` output 1: registered bypass flags to `cp_bypass`.
- `oIF_BP_Bypass_Sel_A` / `oIF_BP_Bypass_Sel_B` output 2: registered bypass source selects.
- `oHazard_Stall` output 1: combinational load-use stall request to IF/PC logic.

## Operation
Tracking state (the ID entry):
- `rID_Valid`, `rID_Dest`, `rID_Src`.
- `rID_Valid` is set only if the issued instruction had `iIF_Valid && iIF_Write_En` and `iIF_Write_Addr != 0`.

Match for port X:
- `mX = iIF_Valid && iIF_Read_En_X && rID_Valid && (iIF_RF_Read_Addr_X == rID_Dest)`.
- r0 never matches, because `rID_Valid` excludes dest 0.

Hazard:
- `oHazard_Stall = LOAD_USE_STALL && (mA || mB) && rID_Src == LSU && !iFlush`.

Register update on each rising edge, in priority order:
1. **Reset or flush:** `rID_Valid`=0, both flags=0, both selects=ALU code (0).
2. **`iStall`=1:** all registers hold.
3. **`oHazard_Stall`=1:** insert a bubble. `rID_Valid`=0, flags=0, selects=0. IF keeps the same instruction. On the next cycle the dependency is at distance 2 and is resolved by the RF write-port bypass in `cp_bypass`, so no flag is needed.
4. **Otherwise:**
   - Flag X ← `mX`, select X ← `mX ? rID_Src : 0`.
   - ID entry ← IF instruction, with valid gated as above.
   - If `iIF_Valid`=0, the ID entry becomes invalid and the flags are 0.

Rules:
- A same-cycle dependency on both ports produces both flags with identical selects.
- A self-dependency (read == write in the same instruction) compares against the older ID entry only, never against itself.
- Select codes pass through unchanged. Width is 2 bits with no decode.

## Timing
- Cycle N: the instruction is in IF and is compared against the instruction that entered ID at the edge ending N-1.
- Edge ending N: the flags are registered. During N+1 the instruction is in ID and the producer is in EX, so `cp_bypass` selects the EX result.
- Latency from IF inputs to flags is exactly 1 cycle. `oHazard_Stall` has 0-cycle latency and is combinational from the IF inputs and the ID entry.
- Reset values: all outputs 0, `rID_Valid`=0. Reset may assert mid-operation and clears state immediately (asynchronously).
- Flush and stall in the same cycle: flush wins.
- Hazard and `iStall` in the same cycle: hold wins. The stall output stays asserted until the hold releases, then one bubble is inserted.

## Structure
- The `RISC24_CP_BYPASS_SRC_*` codes and `DEF_CP_RF_INDEX_WIDTH` come from the shared `def-cp.v`. No new constants are defined locally.
- One sub-module is natural: `cp_bypass_cmp`. It is a per-port comparator, instantiated twice, and produces `mX` and the select.
- Total size is about 150–200 lines of RTL.

## Test plan
- **Back-to-back ALU dependency:** I1 `add r3` (src ALU), then I2 reads r3 on A. Expect flag A=1 and sel A=ALU in I2's ID cycle. Flag B=0.
- **r0 write:** I1 writes r0 (MUL), then I2 reads r0 on A and B. Expect both flags 0.
- **Load-use with `LOAD_USE_STALL`=1:** I1 `ld r5`, then I2 reads r5 on B. Expect `oHazard_Stall`=1 for one cycle, a bubble (flags 0), then I2 issues with flags 0. With `LOAD_USE_STALL`=0, expect no stall and flag B=1, sel=LSU.
- **Hold:** a dependency is pending while `iStall` is high for 3 cycles. Expect outputs and the ID entry to hold, then the correct flags on release.
- **Flush and stall together:** I1 writes r7, then `iFlush` and `iStall` assert together while I2 reads r7. Expect flags 0 and `rID_Valid`=0, with flush winning over stall. After the flush, a read of r7 gives flag 0.
- **Async reset mid-stream:** assert `iReset_n`=0 between clock edges while flags=1. Expect outputs to go to 0 immediately.
